// File: rtl/piece_sequencer.sv
// Purpose : tetromino preview queue, active-piece and hold-slot manager feeding the game FSM.
// Latency : spawn/hold accepted on the request edge; cur_piece and spawn_valid visible 1 cycle later.
// Backpr. : generator codes dropped when the queue is full (unless popped same cycle); spawn on an
//           empty queue is held pending (stall=1) until a piece arrives.
//
// Ports:
//   clk, nreset                  clock and asynchronous active-low reset
//   gen_ready, gen_piece[2:0]    generator strobe and code (7 = invalid, never queued)
//   spawn_req, hold_req          single-cycle requests from the game FSM
//   spawn_valid                  one-cycle pulse: cur_piece just took a new value
//   cur_piece, hold_piece        active / held piece codes (7 = none)
//   preview[3*DEPTH-1:0]         queue contents, [2:0] = head; empty slots read 7
//   preview_count                number of valid queue entries
//   hold_valid, hold_lock        hold slot occupied / hold used since last spawn
//   stall                        spawn pending on an empty queue
module piece_sequencer #(
    parameter int DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 gen_ready,
    input  logic [2:0]           gen_piece,
    input  logic                 spawn_req,
    input  logic                 hold_req,
    output logic                 spawn_valid,
    output logic [2:0]           cur_piece,
    output logic [3*DEPTH-1:0]   preview,
    output logic [2:0]           preview_count,
    output logic [2:0]           hold_piece,
    output logic                 hold_valid,
    output logic                 hold_lock,
    output logic                 stall
);

    localparam logic [2:0] NONE    = 3'd7;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] q_q [DEPTH];
    logic [2:0] q_d [DEPTH];
    logic [2:0] cnt_q, cnt_d, cnt_pop;
    logic [2:0] cur_q, cur_d;
    logic [2:0] hold_q, hold_d;
    logic       hv_q, hv_d;
    logic       lock_q, lock_d;
    logic       pend_q, pend_d;
    logic       sv_q, sv_d;

    logic       spawn_want, have, spawn_fire;
    logic       hold_ok, hold_swap, hold_fill;
    logic       pop, push;

    // Request decode. The pending flag counts as an outstanding spawn, so
    // a hold is refused while one is waiting; this keeps spawn priority
    // consistent whether the spawn was just requested or is still queued.
    // Spawn service looks only at the registered count: a piece pushed
    // this cycle cannot be spawned until the next one.
    always_comb begin
        spawn_want = spawn_req | pend_q;
        have       = (cnt_q != 3'd0);
        spawn_fire = spawn_want & have;
        hold_ok    = (state_q == ACTIVE) & ~lock_q & ~spawn_want & hold_req;
        hold_swap  = hold_ok & hv_q;
        hold_fill  = hold_ok & ~hv_q & have;
        pop        = spawn_fire | hold_fill;
        cnt_pop    = cnt_q - {2'b00, pop};
        // A pop in the same cycle frees the tail slot of a full queue.
        push       = gen_ready & (gen_piece != NONE) & (cnt_pop < DEPTH_C);
        cnt_d      = cnt_pop + {2'b00, push};
    end

    // Queue next-state: shift toward the head on pop (refilling the top
    // slot with NONE so empty entries always read 7), then write the new
    // code at the first free slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_d[i] = q_q[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                q_d[i] = q_q[i + 1];
            end
            q_d[DEPTH - 1] = NONE;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (cnt_pop == 3'(i))) begin
                q_d[i] = gen_piece;
            end
        end
    end

    // FSM next-state and piece/hold bookkeeping.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        hold_d  = hold_q;
        hv_d    = hv_q;
        lock_d  = lock_q;
        pend_d  = pend_q;
        sv_d    = 1'b0;

        case (state_q)
            FILL: begin
                if (spawn_fire) begin
                    state_d = ACTIVE;
                end else if (cnt_d == DEPTH_C) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (spawn_fire) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                state_d = ACTIVE;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (spawn_fire) begin
            cur_d  = q_q[0];
            lock_d = 1'b0;
            pend_d = 1'b0;
            sv_d   = 1'b1;
        end else if (spawn_want) begin
            // Empty queue: remember the request; repeats merge into it.
            pend_d = 1'b1;
        end else if (hold_swap) begin
            cur_d  = hold_q;
            hold_d = cur_q;
            lock_d = 1'b1;
            sv_d   = 1'b1;
        end else if (hold_fill) begin
            hold_d = cur_q;
            hv_d   = 1'b1;
            cur_d  = q_q[0];
            lock_d = 1'b1;
            sv_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= FILL;
            cnt_q   <= 3'd0;
            cur_q   <= NONE;
            hold_q  <= NONE;
            hv_q    <= 1'b0;
            lock_q  <= 1'b0;
            pend_q  <= 1'b0;
            sv_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= NONE;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            hold_q  <= hold_d;
            hv_q    <= hv_d;
            lock_q  <= lock_d;
            pend_q  <= pend_d;
            sv_q    <= sv_d;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= q_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            preview[3*i +: 3] = q_q[i];
        end
    end

    assign spawn_valid   = sv_q;
    assign cur_piece     = cur_q;
    assign preview_count = cnt_q;
    assign hold_piece    = hold_q;
    assign hold_valid    = hv_q;
    assign hold_lock     = lock_q;
    assign stall         = pend_q;

endmodule

// File: tb/tb_piece_sequencer.sv
// Purpose : self-checking bench for piece_sequencer: queue-based reference model plus
//           a spawn_valid scoreboard monitor, directed scenarios then randomized traffic.
// Ports   : none (top-level bench).
module tb_piece_sequencer;

    localparam int DEPTH = 3;

    logic               clk = 1'b0;
    logic               nreset = 1'b0;
    logic               gen_ready = 1'b0;
    logic [2:0]         gen_piece = 3'd0;
    logic               spawn_req = 1'b0;
    logic               hold_req = 1'b0;
    logic               spawn_valid;
    logic [2:0]         cur_piece;
    logic [3*DEPTH-1:0] preview;
    logic [2:0]         preview_count;
    logic [2:0]         hold_piece;
    logic               hold_valid;
    logic               hold_lock;
    logic               stall;

    piece_sequencer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .nreset        (nreset),
        .gen_ready     (gen_ready),
        .gen_piece     (gen_piece),
        .spawn_req     (spawn_req),
        .hold_req      (hold_req),
        .spawn_valid   (spawn_valid),
        .cur_piece     (cur_piece),
        .preview       (preview),
        .preview_count (preview_count),
        .hold_piece    (hold_piece),
        .hold_valid    (hold_valid),
        .hold_lock     (hold_lock),
        .stall         (stall)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         at;
        logic [2:0] cur;
    } exp_t;
    exp_t expq[$];

    // Reference model: plain queue of codes plus scalar slots.
    logic [2:0] mq[$];
    logic [2:0] m_cur, m_hold;
    bit         m_hv, m_lock, m_pend, m_active;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        expq.delete();
        m_cur = 3'd7; m_hold = 3'd7;
        m_hv = 0; m_lock = 0; m_pend = 0; m_active = 0;
    endtask

    task automatic check_state(input string tag);
        logic [3*DEPTH-1:0] pv;
        pv = '1;
        for (int i = 0; i < mq.size(); i++) pv[3*i +: 3] = mq[i];
        chk({tag, " preview"},       32'(preview),       32'(pv));
        chk({tag, " preview_count"}, 32'(preview_count), 32'(mq.size()));
        chk({tag, " cur_piece"},     32'(cur_piece),     32'(m_cur));
        chk({tag, " hold_piece"},    32'(hold_piece),    32'(m_hold));
        chk({tag, " hold_valid"},    32'(hold_valid),    32'(m_hv));
        chk({tag, " hold_lock"},     32'(hold_lock),     32'(m_lock));
        chk({tag, " stall"},         32'(stall),         32'(m_pend));
    endtask

    // Called at a negedge: drive one cycle of inputs, advance the model,
    // then compare full state at the following negedge.
    task automatic step(input bit gr, input logic [2:0] gp, input bit sr, input bit hr);
        bit         sv;
        logic [2:0] t;
        exp_t       e;
        gen_ready = gr; gen_piece = gp; spawn_req = sr; hold_req = hr;
        sv = 0;
        if ((sr || m_pend) && mq.size() > 0) begin
            m_cur = mq.pop_front(); m_lock = 0; m_pend = 0; m_active = 1; sv = 1;
        end else if (sr || m_pend) begin
            m_pend = 1;
        end else if (hr && m_active && !m_lock) begin
            if (m_hv) begin
                t = m_cur; m_cur = m_hold; m_hold = t; m_lock = 1; sv = 1;
            end else if (mq.size() > 0) begin
                m_hold = m_cur; m_hv = 1; m_cur = mq.pop_front(); m_lock = 1; sv = 1;
            end
        end
        if (gr && gp != 3'd7 && mq.size() < DEPTH) mq.push_back(gp);
        if (sv) begin
            e.at = cyc + 1; e.cur = m_cur;
            expq.push_back(e);
        end
        @(negedge clk);
        check_state("step");
    endtask

    // Called at a negedge: async reset, immediate check, release one cycle later.
    task automatic do_reset(input string tag);
        nreset = 1'b0;
        gen_ready = 0; gen_piece = 0; spawn_req = 0; hold_req = 0;
        #1;
        model_reset();
        check_state(tag);
        chk({tag, " spawn_valid"}, 32'(spawn_valid), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    // Scoreboard monitor: every spawn_valid pulse must match the oldest
    // expectation in both cycle and piece code.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (expq.size() > 0 && expq[0].at == cyc) begin
                e = expq.pop_front();
                chk("spawn_valid pulse", 32'(spawn_valid), 32'd1);
                chk("spawn cur_piece",   32'(cur_piece),   32'(e.cur));
            end else if (spawn_valid) begin
                chk("spawn_valid unexpected", 32'(spawn_valid), 32'd0);
            end
        end
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset("reset");

        // Fill: 3,5,1 then 6 dropped.
        step(1, 3'd3, 0, 0);
        step(1, 3'd5, 0, 0);
        step(1, 3'd1, 0, 0);
        step(1, 3'd6, 0, 0);
        chk("fill preview", 32'(preview), 32'(9'b001_101_011));
        chk("fill count",   32'(preview_count), 32'd3);

        // Spawn from full queue.
        step(0, 3'd0, 1, 0);
        chk("spawn cur", 32'(cur_piece), 32'd3);
        chk("spawn count", 32'(preview_count), 32'd2);

        // Hold into empty slot, repeated hold ignored, spawn, then swap.
        step(0, 3'd0, 0, 1);
        chk("hold fill hold_piece", 32'(hold_piece), 32'd3);
        chk("hold fill cur", 32'(cur_piece), 32'd5);
        step(0, 3'd0, 0, 1);
        step(0, 3'd0, 1, 0);
        step(0, 3'd0, 0, 1);
        chk("swap cur", 32'(cur_piece), 32'd3);
        chk("swap hold", 32'(hold_piece), 32'd1);

        // Spawn on empty queue stalls until a piece arrives.
        step(0, 3'd0, 1, 0);
        step(0, 3'd0, 1, 0);
        step(1, 3'd4, 0, 0);
        step(0, 3'd0, 0, 0);
        chk("stall served cur", 32'(cur_piece), 32'd4);
        step(0, 3'd0, 0, 0);

        // Full queue with simultaneous push and spawn; invalid code ignored.
        step(1, 3'd0, 0, 0);
        step(1, 3'd6, 0, 0);
        step(1, 3'd5, 0, 0);
        step(1, 3'd2, 1, 0);
        chk("push+pop preview", 32'(preview), 32'(9'b010_101_110));
        step(1, 3'd7, 0, 0);
        step(0, 3'd7, 0, 0);

        // Drain and leave a spawn pending with hold occupied, then reset.
        step(0, 3'd0, 1, 0);
        step(0, 3'd0, 1, 0);
        step(0, 3'd0, 1, 0);
        step(0, 3'd0, 1, 0);
        chk("pre-reset stall", 32'(stall), 32'd1);
        chk("pre-reset hold_valid", 32'(hold_valid), 32'd1);
        do_reset("mid reset");
        for (int i = 0; i < 4; i++) step(1, 3'($urandom_range(0, 6)), 0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rand reset");
            end else begin
                step($urandom_range(0, 1) == 1,
                     3'($urandom_range(0, 7)),
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 6) == 0);
            end
        end
        step(0, 3'd0, 0, 0);
        step(0, 3'd0, 0, 0);
        chk("scoreboard drained", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piece_sequencer.md
PIECE_SEQUENCER -- requirements
Module: piece_sequencer

Interface
REQ-001 Parameter: DEPTH, default 3, number of preview queue entries (range 1-7).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 nreset  input  1  asynchronous, active-low reset.
REQ-004 gen_ready  input  1  piecegenerator output valid strobe.
REQ-005 gen_piece  input  3  piecegenerator code; 0-6 = tetromino, 7 = invalid.
REQ-006 spawn_req  input  1  game FSM requests a new active piece; single-cycle pulse.
REQ-007 hold_req  input  1  game FSM requests hold/swap of active piece; single-cycle pulse.
REQ-008 spawn_valid  output  1  one-cycle pulse: cur_piece updated with a newly spawned piece.
REQ-009 cur_piece  output  3  active piece code; 7 = none.
REQ-010 preview  output  3*DEPTH  queue contents; bits [2:0] = head (oldest); empty slots read 7.
REQ-011 preview_count  output  3  number of valid queue entries, 0..DEPTH.
REQ-012 hold_piece  output  3  held piece code; 7 = none.
REQ-013 hold_valid  output  1  hold slot occupied.
REQ-014 hold_lock  output  1  hold already used since last spawn.
REQ-015 stall  output  1  a spawn request is pending on an empty queue.

Function
REQ-016 FSM states: FILL (post-reset, no active piece), IDLE (queue full, no active piece), ACTIVE (piece in play).
REQ-017 FILL -> IDLE when preview_count reaches DEPTH; a spawn_req in FILL or IDLE with preview_count>=1 -> ACTIVE directly.
REQ-018 Push: gen_ready=1, gen_piece!=7 and (preview_count<DEPTH or a pop in the same cycle) -> code appended at tail; otherwise the code is dropped.
REQ-019 gen_piece=7 never enters the queue, regardless of gen_ready.
REQ-020 Push and pop in the same cycle on a full queue: both occur, preview_count unchanged, order preserved.
REQ-021 Accepted spawn: spawn_req=1 (or pending flag set) and preview_count>=1 -> head popped into cur_piece, hold_lock cleared, spawn_valid=1 the next cycle (1-cycle latency).
REQ-022 spawn_req with preview_count=0 -> pending flag set, stall=1 from next cycle; spawn served on the first cycle preview_count>=1, counting a push in that same cycle only from the following cycle.
REQ-023 Further spawn_req while pending is merged (no second spawn).
REQ-024 Hold accepted only in ACTIVE with hold_lock=0 and no spawn_req in the same cycle; otherwise ignored.
REQ-025 Hold with hold_valid=0 and preview_count>=1: hold_piece<=cur_piece, hold_valid<=1, cur_piece<=head, pop; with preview_count=0 hold is ignored.
REQ-026 Hold with hold_valid=1: cur_piece and hold_piece swap, no pop.
REQ-027 Accepted hold sets hold_lock=1 and pulses spawn_valid the next cycle.
REQ-028 spawn_req and hold_req together: spawn wins, hold dropped.
REQ-029 spawn_valid is never high two consecutive cycles from a single request; preview_count never exceeds DEPTH or underflows.

Reset
REQ-030 nreset=0 immediately: cur_piece=7, hold_piece=7, all preview slots=7, preview_count=0, spawn_valid=0, hold_valid=0, hold_lock=0, stall=0, pending cleared, state FILL.
REQ-031 Reset mid-operation discards queue, hold, and pending spawn; no spawn_valid after deassertion until a new spawn_req.

Verification
REQ-032 Reset, gen_ready pulses codes 3,5,1 (DEPTH=3) -> preview_count=3, preview={1,5,3}, state IDLE; extra code 6 dropped.
REQ-033 Queue {1,5,3}, spawn_req -> next cycle spawn_valid=1, cur_piece=3, preview_count=2, hold_lock=0.
REQ-034 cur_piece=3, hold empty, hold_req -> hold_piece=3, cur_piece=5, hold_lock=1; second hold_req ignored; spawn_req then hold_req -> cur and hold swap.
REQ-035 Empty queue, spawn_req -> stall=1, no spawn_valid; push code 4 -> spawn_valid=1, cur_piece=4, stall=0.
REQ-036 Full queue, gen_ready with code 2 and spawn_req same cycle -> head popped, 2 appended, preview_count stays 3; gen_piece=7 with gen_ready -> no change.
REQ-037 nreset pulsed while ACTIVE with hold_valid=1 and stall=1 -> all outputs at REQ-030 values, no spawn_valid afterwards.
